led_pwm_blinker: RTL and testbench



---
 rtl/led_pwm_pkg.sv | 24 ++
 rtl/led_tick_prescaler.sv | 29 ++
 rtl/led_pwm_blinker.sv | 152 +++++++++++++++
 tb/tb_led_pwm_blinker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM/blink gate: register map, CTRL bit positions,
// blink FSM encoding and reset values.
package led_pwm_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_BLINK_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PH_ON  = 2'd1,
        PH_OFF = 2'd2
    } blink_state_t;

    localparam logic        RST_ENABLE      = 1'b0;
    localparam logic        RST_BLINK_EN    = 1'b0;
    localparam logic [15:0] RST_PERIOD      = 16'h0000;
    localparam logic        RST_BLINK_PHASE = 1'b1;

endpackage

// File: rtl/led_tick_prescaler.sv
// Blink time base: counts 0..TICK_DIV-1 while enabled and pulses tick for one cycle
// on the last count. Held at zero whenever enable is low.
module led_tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/led_pwm_blinker.sv
// Gates the PIO LED pattern with a global PWM brightness and an optional blink cadence,
// configured over a 4-word Avalon-MM slave. Define LED_PWM_GAMMA_EN for squared duty mapping.
module led_pwm_blinker
    import led_pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50000,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [WIDTH-1:0]    pattern_in,
    output logic [WIDTH-1:0]    led_out
);

    logic                enable;
    logic                blink_en;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_shadow;
    logic [PWM_BITS-1:0] duty_eff;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [15:0]         period;
    logic [15:0]         blink_cnt;
    blink_state_t        state;
    logic                blink_phase;
    logic                tick;
    logic                pwm_on;
    logic                wr;
    logic                period_wr;
    logic [31:0]         status_word;
    logic                unused_writedata;

    assign wr               = chipselect && !write_n;
    assign period_wr        = wr && (address == ADDR_PERIOD);
    assign unused_writedata = ^writedata[31:16];

    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= RST_ENABLE;
            blink_en <= RST_BLINK_EN;
            duty     <= '1;
            period   <= RST_PERIOD;
        end else if (wr) begin
            case (address)
                ADDR_CTRL: begin
                    enable   <= writedata[CTRL_ENABLE_BIT];
                    blink_en <= writedata[CTRL_BLINK_BIT];
                end
                ADDR_DUTY:   duty   <= writedata[PWM_BITS-1:0];
                ADDR_PERIOD: period <= writedata[15:0];
                default: ;
            endcase
        end
    end

    led_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // The shadow only follows DUTY at the PWM wrap, so every PWM period is whole.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt     <= '0;
            duty_shadow <= '1;
        end else begin
            pwm_cnt <= enable ? pwm_cnt + PWM_BITS'(1) : '0;
            if (pwm_cnt == '1) begin
                duty_shadow <= duty;
            end
        end
    end

`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;
    assign duty_sq  = {{PWM_BITS{1'b0}}, duty_shadow} * {{PWM_BITS{1'b0}}, duty_shadow};
    assign duty_eff = (duty_shadow == '1) ? '1 : PWM_BITS'(duty_sq >> PWM_BITS);
`else
    assign duty_eff = duty_shadow;
`endif

    assign pwm_on = (duty_eff == '1) || (pwm_cnt < duty_eff);

    // A PERIOD write restarts the current phase and takes priority over a same-cycle tick.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state       <= IDLE;
            blink_cnt   <= '0;
            blink_phase <= RST_BLINK_PHASE;
        end else begin
            case (state)
                IDLE: begin
                    state       <= PH_ON;
                    blink_cnt   <= '0;
                    blink_phase <= 1'b1;
                end
                PH_ON, PH_OFF: begin
                    if (!blink_en || period == 16'd0) begin
                        state       <= PH_ON;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b1;
                    end else if (period_wr) begin
                        blink_cnt <= '0;
                    end else if (tick) begin
                        if (blink_cnt == period - 16'd1) begin
                            blink_cnt   <= '0;
                            state       <= (state == PH_ON) ? PH_OFF : PH_ON;
                            blink_phase <= (state == PH_OFF);
                        end else begin
                            blink_cnt <= blink_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    blink_cnt   <= '0;
                    blink_phase <= RST_BLINK_PHASE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
        end else begin
            led_out <= pattern_in & {WIDTH{(state != IDLE) && pwm_on && blink_phase}};
        end
    end

    assign status_word = (32'(duty_eff) << 8) | {29'd0, state, blink_phase};

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = {30'd0, blink_en, enable};
            ADDR_DUTY:   readdata[PWM_BITS-1:0] = duty;
            ADDR_PERIOD: readdata[15:0] = period;
            default:     readdata = status_word;
        endcase
    end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Self-checking bench for led_pwm_blinker: directed register scenarios followed by
// randomized traffic, all compared cycle by cycle against an arithmetic reference model.
module tb_led_pwm_blinker;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int PWM_BITS = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [WIDTH-1:0]  pattern_in;
    logic [WIDTH-1:0]  led_out;

    always #5 clk = ~clk;

    led_pwm_blinker #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pattern_in (pattern_in),
        .led_out    (led_out)
    );

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: time since enable (m_k) gives PWM position and tick timing by
    // modular arithmetic; the blink is tracked as ticks elapsed in the current half-period.
    bit m_en, m_blink, m_run, m_phase;
    int m_duty, m_period, m_shadow, m_k, m_ticks, m_led;

    function automatic int gammaOf(input int d);
`ifdef LED_PWM_GAMMA_EN
        return (d == 255) ? 255 : (d * d) / 256;
`else
        return d;
`endif
    endfunction

    function automatic int modelRead(input int a);
        int stateCode;
        stateCode = m_run ? (m_phase ? 1 : 2) : 0;
        case (a)
            0:       return int'(m_blink) * 2 + int'(m_en);
            1:       return m_duty;
            2:       return m_period;
            default: return gammaOf(m_shadow) * 256 + stateCode * 2 + int'(m_phase);
        endcase
    endfunction

    task automatic modelStep(input bit rst, input bit doWrite, input int addr,
                             input logic [31:0] data, input int pattern);
        int  pwm;
        int  eff;
        bit  tick;
        bit  on;
        if (rst) begin
            m_en = 0; m_blink = 0; m_duty = 255; m_period = 0; m_shadow = 255;
            m_k = 0; m_run = 0; m_phase = 1; m_ticks = 0; m_led = 0;
            return;
        end
        pwm   = m_k % 256;
        tick  = m_en && ((m_k % TICK_DIV) == TICK_DIV - 1);
        eff   = gammaOf(m_shadow);
        on    = (eff == 255) || (pwm < eff);
        m_led = (m_run && on && m_phase) ? pattern : 0;
        if (!m_en) begin
            m_run = 0; m_phase = 1; m_ticks = 0;
        end else if (!m_run) begin
            m_run = 1; m_phase = 1; m_ticks = 0;
        end else if (!m_blink || m_period == 0) begin
            m_phase = 1; m_ticks = 0;
        end else if (doWrite && addr == 2) begin
            m_ticks = 0;
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == m_period) begin
                m_ticks = 0;
                m_phase = !m_phase;
            end
        end
        if (m_en && pwm == 255) m_shadow = m_duty;
        m_k = m_en ? m_k + 1 : 0;
        if (doWrite) begin
            case (addr)
                0: begin m_en = data[0]; m_blink = data[1]; end
                1: m_duty = int'(data[7:0]);
                2: m_period = int'(data[15:0]);
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit doWrite, input int addr,
                                 input logic [31:0] data, input int pattern);
        reset      = rst;
        chipselect = doWrite;
        write_n    = !doWrite;
        address    = 2'(addr);
        writedata  = data;
        pattern_in = 8'(pattern);
        @(posedge clk);
        modelStep(rst, doWrite, addr, data, pattern);
        #1;
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        checkOutput("led_model", 32'(led_out), m_led);
    endtask

    task automatic checkRead(input int a, input string tag);
        address = 2'(a);
        #1;
        checkOutput(tag, readdata, modelRead(a));
    endtask

    int curPattern;

    task automatic step();
        applyStimulus(1'b0, 1'b0, 0, 32'd0, curPattern);
    endtask

    task automatic writeReg(input int a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, a, d, curPattern);
    endtask

    initial begin
        int onCount;
        int runLen;
        int changes;
        int expEff;
        logic [7:0] prevLed;

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
        writedata = 32'd0; curPattern = 'hA5; pattern_in = 8'hA5;

        // Reset state
        applyStimulus(1'b1, 1'b0, 0, 32'd0, curPattern);
        applyStimulus(1'b1, 1'b0, 0, 32'd0, curPattern);
        checkOutput("reset_led", 32'(led_out), 32'h0);
        checkRead(1, "reset_duty_model");
        checkOutput("reset_duty", readdata, 32'h0000_00FF);
        checkRead(3, "reset_status_model");
        checkOutput("reset_status_low", readdata & 32'h7, 32'h1);
        checkRead(0, "reset_ctrl_model");

        // Full-brightness pass-through
        curPattern = 'h3C;
        writeReg(1, 32'hFF);
        writeReg(0, 32'h1);
        step();
        checkOutput("pass_first_cycle_off", 32'(led_out), 32'h0);
        step();
        checkOutput("pass_two_cycles", 32'(led_out), 32'h3C);
        repeat (20) step();
        checkOutput("pass_steady", 32'(led_out), 32'h3C);

        // Quarter duty: 64 of every 256 cycles on
        writeReg(1, 32'h40);
        repeat (300) step();
        onCount = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            if (led_out == 8'h3C) onCount++;
        end
        checkOutput("duty40_on_cycles", onCount, 128);
        checkRead(3, "duty40_status");

        // Duty zero written mid-period takes effect after the wrap
        repeat (37) step();
        writeReg(1, 32'h00);
        repeat (300) step();
        onCount = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led_out != 8'h00) onCount++;
        end
        checkOutput("duty0_on_cycles", onCount, 0);

        // Blink at 8-cycle half-periods
        writeReg(1, 32'hFF);
        repeat (300) step();
        writeReg(2, 32'd2);
        writeReg(0, 32'h3);
        prevLed = led_out;
        runLen = 0;
        changes = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            checkRead(3, "blink_status");
            runLen++;
            if (led_out != prevLed) begin
                if (changes > 0) checkOutput("blink_run_len", runLen, 8);
                changes++;
                runLen = 0;
                prevLed = led_out;
            end
        end
        checkOutput("blink_toggled", (changes >= 8) ? 32'd1 : 32'd0, 32'd1);

        // Disable while in the off phase, then re-enable
        for (int i = 0; i < 40 && !(m_run && !m_phase); i++) step();
        address = 2'd3;
        #1;
        checkOutput("ph_off_reached", (readdata >> 1) & 32'h3, 32'h2);
        writeReg(0, 32'h0);
        step();
        address = 2'd3;
        #1;
        checkOutput("disable_state_idle", (readdata >> 1) & 32'h3, 32'h0);
        checkOutput("disable_led_off", 32'(led_out), 32'h0);
        writeReg(0, 32'h3);
        step();
        address = 2'd3;
        #1;
        checkOutput("reenable_ph_on", (readdata >> 1) & 32'h3, 32'h1);
        repeat (20) begin
            step();
            checkRead(3, "reenable_status");
        end

        // Reset mid-blink
        repeat (5) step();
        applyStimulus(1'b1, 1'b0, 0, 32'd0, curPattern);
        checkOutput("midreset_led", 32'(led_out), 32'h0);
        address = 2'd0;
        #1;
        checkOutput("midreset_ctrl", readdata, 32'h0);
        address = 2'd3;
        #1;
        checkOutput("midreset_state", (readdata >> 1) & 32'h3, 32'h0);

        // Duty mapping visible in STATUS[15:8]
        writeReg(1, 32'h80);
        writeReg(0, 32'h1);
        repeat (300) step();
        address = 2'd3;
        #1;
`ifdef LED_PWM_GAMMA_EN
        expEff = 'h40;
`else
        expEff = 'h80;
`endif
        checkOutput("status_duty_eff", (readdata >> 8) & 32'hFF, expEff);

        // Randomized register traffic and patterns
        for (int i = 0; i < 600; i++) begin
            int r;
            int a;
            logic [31:0] d;
            curPattern = int'($urandom_range(0, 255));
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                applyStimulus(1'b1, 1'b0, 0, 32'd0, curPattern);
            end else if (r < 25) begin
                a = int'($urandom_range(0, 3));
                d = $urandom;
                if (a == 0) d = (d & 32'hFFFF_FFFC) | ((d[4:3] == 2'b00) ? 32'h0 : 32'h3);
                if (a == 2) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
                writeReg(a, d);
            end else begin
                step();
            end
            if ((i % 4) == 0) checkRead(i % 16 / 4, "random_read");
        end

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
